// File: rtl/ram_fifo_ctrl_if.sv
// Signal bundle between ram_fifo_ctrl, its producer/consumer pair and the 16x8 dual-port RAM.
// The slave modport is the controller's view; master is the surrounding environment's view.
interface ram_fifo_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              ram_write;
   logic [ADDR_W-1:0] ram_wr_addr;
   logic [DATA_W-1:0] ram_data_in;
   logic              ram_read;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [DATA_W-1:0] ram_data_out;
   logic [ADDR_W+1:0] count;
   logic              empty;
   logic              full;

   modport slave (
      input  flush, in_valid, in_data, out_ready, ram_data_out,
      output in_ready, out_valid, out_data, ram_write, ram_wr_addr, ram_data_in,
             ram_read, ram_rd_addr, count, empty, full
   );

   modport master (
      output flush, in_valid, in_data, out_ready, ram_data_out,
      input  in_ready, out_valid, out_data, ram_write, ram_wr_addr, ram_data_in,
             ram_read, ram_rd_addr, count, empty, full
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Runs a 1-cycle-latency dual-port RAM as a synchronous FIFO; a 2-entry skid buffer
// absorbs the read latency so one push and one pop can complete every cycle.
module ram_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   ram_fifo_ctrl_if.slave   bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int CW    = ADDR_W + 1;
   localparam int NW    = ADDR_W + 2;
   localparam logic [CW-1:0] RAM_FULL = CW'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     ram_cnt_q, ram_cnt_d;
   logic              inflight_q, inflight_d;
   logic [DATA_W-1:0] skid_q [2];
   logic [DATA_W-1:0] skid_d [2];
   logic              head_q, head_d;
   logic              tail_q, tail_d;
   logic [1:0]        skid_cnt_q, skid_cnt_d;
   logic [NW-1:0]     count_q, count_d;

   logic              in_ready_w;
   logic              push;
   logic              pop;
   logic              rd_issue;
   logic [2:0]        occ;

   always_comb begin
      in_ready_w = !rst && (ram_cnt_q != RAM_FULL) && !bus.flush;
      push       = bus.in_valid && in_ready_w;
      pop        = (skid_cnt_q != 2'd0) && bus.out_ready;
      // Skid slots committed after this edge; a pop this cycle frees one for a new read.
      occ        = 3'(skid_cnt_q) + 3'(inflight_q) - 3'(pop);
      rd_issue   = (ram_cnt_q != '0) && (occ < 3'd2) && !bus.flush;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ram_cnt_d  = ram_cnt_q;
      inflight_d = inflight_q;
      skid_d[0]  = skid_q[0];
      skid_d[1]  = skid_q[1];
      head_d     = head_q;
      tail_d     = tail_q;
      skid_cnt_d = skid_cnt_q;

      if (bus.flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         ram_cnt_d  = '0;
         inflight_d = 1'b0;
         skid_d[0]  = '0;
         skid_d[1]  = '0;
         head_d     = 1'b0;
         tail_d     = 1'b0;
         skid_cnt_d = '0;
      end else begin
         if (push)     wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (rd_issue) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(rd_issue);
         inflight_d = rd_issue;
         if (inflight_q) begin
            skid_d[tail_q] = bus.ram_data_out;
            tail_d         = ~tail_q;
         end
         if (pop) head_d = ~head_q;
         skid_cnt_d = skid_cnt_q + 2'(inflight_q) - 2'(pop);
      end

      count_d = NW'(ram_cnt_d) + NW'(inflight_d) + NW'(skid_cnt_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         inflight_q <= 1'b0;
         skid_q[0]  <= '0;
         skid_q[1]  <= '0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         skid_cnt_q <= '0;
         count_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         inflight_q <= inflight_d;
         skid_q[0]  <= skid_d[0];
         skid_q[1]  <= skid_d[1];
         head_q     <= head_d;
         tail_q     <= tail_d;
         skid_cnt_q <= skid_cnt_d;
         count_q    <= count_d;
      end
   end

   assign bus.in_ready    = in_ready_w;
   assign bus.full        = !rst && !in_ready_w;
   assign bus.ram_write   = push;
   assign bus.ram_wr_addr = wr_ptr_q;
   assign bus.ram_data_in = bus.in_data;
   assign bus.ram_read    = rd_issue;
   assign bus.ram_rd_addr = rd_ptr_q;
   assign bus.out_valid   = (skid_cnt_q != 2'd0);
   assign bus.out_data    = skid_q[head_q];
   assign bus.count       = count_q;
   assign bus.empty       = (count_q == '0);
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboarded bench for ram_fifo_ctrl with a behavioural 16x8 RAM; expected data is a plain
// queue of accepted words, popped by a negedge monitor whenever the DUT hands a word out.
module tb_ram_fifo_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
   ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [DW-1:0] mem [16];
   logic [DW-1:0] ram_q = '0;
   always @(posedge clk) begin
      if (bus.ram_write) mem[bus.ram_wr_addr] <= bus.ram_data_in;
      if (bus.ram_read)  ram_q <= mem[bus.ram_rd_addr];
   end
   assign bus.ram_data_out = ram_q;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   logic [DW-1:0] model_q [$];
   int wp = 0;
   bit lat_arm = 0;
   int acc_cyc = -1, val_cyc = -1;
   int pop_first = -1, pop_last = -1;
   bit done_push = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (rst) begin
         model_q.delete();
         wp = 0;
      end else begin
         chk(int'(bus.count) == model_q.size(), "count", int'(bus.count), model_q.size());
         chk(bus.empty == (model_q.size() == 0), "empty", int'(bus.empty), int'(model_q.size() == 0));
         chk(bus.count <= 18, "count_max", int'(bus.count), 18);
         if (bus.out_valid && bus.out_ready) begin
            chk(model_q.size() != 0, "pop_unexpected", int'(bus.out_data), -1);
            if (model_q.size() != 0) begin
               e = model_q.pop_front();
               chk(bus.out_data == e, "pop_data", int'(bus.out_data), int'(e));
            end
            if (pop_first < 0) pop_first = cyc;
            pop_last = cyc;
         end
         if (lat_arm && bus.out_valid && val_cyc < 0) val_cyc = cyc;
         if (bus.in_valid && bus.in_ready) begin
            chk(bus.ram_write && bus.ram_wr_addr == 4'(wp) && bus.ram_data_in == bus.in_data,
                "push_ram", int'(bus.ram_wr_addr), wp);
            model_q.push_back(bus.in_data);
            wp = (wp + 1) % 16;
            if (lat_arm && acc_cyc < 0) acc_cyc = cyc;
         end else begin
            chk(!bus.ram_write, "stray_write", int'(bus.ram_write), 0);
         end
         if (bus.flush) begin
            chk(!bus.ram_write && !bus.ram_read && !bus.in_ready, "flush_quiet",
                int'({bus.ram_write, bus.ram_read, bus.in_ready}), 0);
            model_q.delete();
            wp = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      bit done = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = bus.in_ready;
         step();
      end
      chk(done, "push_timeout", int'(done), 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 500 && model_q.size() != 0; i++) @(negedge clk);
      chk(model_q.size() == 0, "drain_timeout", model_q.size(), 0);
      step();
   endtask

   initial begin
      bus.flush = 0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk(!bus.out_valid && bus.out_data == '0 && bus.count == '0 && bus.empty && !bus.full
          && !bus.ram_write && !bus.ram_read && !bus.in_ready, "reset_state",
          int'({bus.out_valid, bus.empty, bus.full, bus.ram_write, bus.ram_read, bus.in_ready}), 'h10);
      rst = 1'b0;
      @(negedge clk);
      chk(bus.in_ready, "ready_after_rst", int'(bus.in_ready), 1);
      step();

      // Basic ordering and latency
      lat_arm = 1; acc_cyc = -1; val_cyc = -1;
      bus.out_ready = 1;
      push_word(8'h11); push_word(8'h22); push_word(8'h33);
      wait_empty();
      chk(val_cyc - acc_cyc == 3, "latency", val_cyc - acc_cyc, 3);
      lat_arm = 0;

      // Fill to capacity with the consumer stalled
      bus.out_ready = 0;
      for (int i = 0; i < 18; i++) push_word(8'(i));
      @(negedge clk);
      chk(bus.count == 18, "fill_count", int'(bus.count), 18);
      chk(!bus.in_ready && bus.full, "fill_full", int'({bus.in_ready, bus.full}), 1);
      step();
      bus.in_valid = 1; bus.in_data = 8'h99;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk(!bus.in_ready && !bus.ram_write, "push_blocked", int'({bus.in_ready, bus.ram_write}), 0);
         step();
      end
      bus.in_valid = 0;
      bus.out_ready = 1;
      wait_empty();
      @(negedge clk);
      chk(bus.empty && !bus.out_valid, "drained", int'({bus.empty, bus.out_valid}), 2);
      step();

      // Streaming: one transfer per cycle, addresses wrap
      pop_first = -1; pop_last = -1;
      for (int i = 0; i < 40; i++) push_word(8'(8'h40 + i));
      wait_empty();
      chk(pop_last - pop_first == 39, "throughput", pop_last - pop_first, 39);

      // Random producer gaps and consumer stalls
      done_push = 0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               repeat ($urandom_range(0, 2)) step();
               push_word(8'($urandom));
            end
            done_push = 1;
         end
         begin
            for (int g = 0; g < 5000 && !(done_push && model_q.size() == 0); g++) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               step();
            end
         end
      join
      chk(model_q.size() == 0, "random_drain", model_q.size(), 0);
      bus.out_ready = 0;
      step();

      // Flush discards stored and in-flight data
      for (int i = 0; i < 5; i++) push_word(8'(8'hC0 + i));
      repeat (3) step();
      bus.flush = 1;
      step();
      bus.flush = 0;
      @(negedge clk);
      chk(bus.count == 0 && bus.empty && !bus.out_valid && bus.in_ready, "post_flush",
          int'({bus.count, bus.empty, bus.out_valid, bus.in_ready}), 'h5);
      step();
      bus.out_ready = 1;
      push_word(8'hAB);
      wait_empty();

      // Async reset with a read in flight
      bus.out_ready = 0;
      push_word(8'h01); push_word(8'h02); push_word(8'h03);
      #2 rst = 1'b1;
      #1;
      chk(!bus.out_valid && bus.out_data == '0 && bus.count == '0 && bus.empty && !bus.full
          && !bus.ram_write && !bus.ram_read && !bus.in_ready, "async_reset",
          int'({bus.out_valid, bus.empty, bus.full, bus.ram_write, bus.ram_read, bus.in_ready}), 'h10);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk(bus.in_ready, "ready_after_rst2", int'(bus.in_ready), 1);
      step();
      bus.out_ready = 1;
      push_word(8'h5A); push_word(8'hA5);
      wait_empty();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
